// File: rtl/pio_divider_meter.sv
// Measures the rate of a PIO clock-enable pulse train over 2^LOG2_PULSES pulses
// and reports it as a 16.8 fixed-point divisor.
module pio_divider_meter #(
  parameter int unsigned LOG2_PULSES = 8,
  parameter int unsigned TIMEOUT     = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] meas_int,
  output logic [7:0]  meas_frac,
  output logic        overflow,
  output logic        timeout
);

  localparam int unsigned CYC_W = 17 + LOG2_PULSES;
  localparam int unsigned PUL_W = LOG2_PULSES + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;
  localparam int unsigned RES_W = CYC_W + 9;

  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'((1 << LOG2_PULSES) - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEASURE
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [PUL_W-1:0] pulse_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic [CYC_W:0]   cyc_total_c;
  logic [RES_W-1:0] scaled_c;
  logic             sat_c;
  logic [23:0]      result_c;

  // Divisor for a completion this cycle: count includes the final pulse cycle.
  always_comb begin
    cyc_total_c = {1'b0, cyc_cnt} + (CYC_W + 1)'(1);
    scaled_c    = {cyc_total_c, 8'h00} >> LOG2_PULSES;
    sat_c       = |scaled_c[RES_W-1:24];
    result_c    = sat_c ? 24'hFF_FFFF : scaled_c[23:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      meas_int  <= '0;
      meas_frac <= '0;
      cyc_cnt   <= '0;
      pulse_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SYNC;
            busy      <= 1'b1;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
            cyc_cnt   <= '0;
            pulse_cnt <= '0;
            wd_cnt    <= '0;
          end
        end

        // The first pulse seen only marks time zero; it is not counted.
        SYNC: begin
          if (penable) begin
            state     <= MEASURE;
            cyc_cnt   <= '0;
            pulse_cnt <= '0;
            wd_cnt    <= '0;
          end else if (wd_cnt == WD_LIMIT) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            valid   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        MEASURE: begin
          if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
          if (penable) begin
            if (pulse_cnt == PUL_LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              valid     <= 1'b1;
              overflow  <= sat_c;
              meas_int  <= result_c[23:8];
              meas_frac <= result_c[7:0];
            end else begin
              pulse_cnt <= pulse_cnt + PUL_W'(1);
              wd_cnt    <= '0;
            end
          end else if (wd_cnt == WD_LIMIT) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            valid   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_divider_meter.sv
// Scoreboard bench: four meter instances with different parameters, each driven
// by gap schedules whose expected result is computed from plain arithmetic.
module tb_pio_divider_meter;

  typedef int iq_t[$];

  typedef struct {
    int          due;
    logic [15:0] mi;
    logic [7:0]  mf;
    logic        v;
    logic        o;
    logic        t;
  } exp_t;

  logic        clk;
  logic        rst   [4];
  logic        pen   [4];
  logic        st    [4];
  logic        busy  [4];
  logic        done  [4];
  logic        valid [4];
  logic [15:0] mi    [4];
  logic [7:0]  mf    [4];
  logic        ovf   [4];
  logic        tmo   [4];

  int          cyc;
  int          checks;
  int          failures;
  exp_t        exp_q [4][$];
  logic [15:0] last_mi [4];
  logic [7:0]  last_mf [4];
  exp_t        mon_e;

  pio_divider_meter #(.LOG2_PULSES(8), .TIMEOUT(131072)) u_main (
    .clk(clk), .reset(rst[0]), .penable(pen[0]), .start(st[0]), .busy(busy[0]),
    .done(done[0]), .valid(valid[0]), .meas_int(mi[0]), .meas_frac(mf[0]),
    .overflow(ovf[0]), .timeout(tmo[0]));

  pio_divider_meter #(.LOG2_PULSES(8), .TIMEOUT(16)) u_to (
    .clk(clk), .reset(rst[1]), .penable(pen[1]), .start(st[1]), .busy(busy[1]),
    .done(done[1]), .valid(valid[1]), .meas_int(mi[1]), .meas_frac(mf[1]),
    .overflow(ovf[1]), .timeout(tmo[1]));

  pio_divider_meter #(.LOG2_PULSES(0), .TIMEOUT(131072)) u_ovf (
    .clk(clk), .reset(rst[2]), .penable(pen[2]), .start(st[2]), .busy(busy[2]),
    .done(done[2]), .valid(valid[2]), .meas_int(mi[2]), .meas_frac(mf[2]),
    .overflow(ovf[2]), .timeout(tmo[2]));

  pio_divider_meter #(.LOG2_PULSES(3), .TIMEOUT(32)) u_rnd (
    .clk(clk), .reset(rst[3]), .penable(pen[3]), .start(st[3]), .busy(busy[3]),
    .done(done[3]), .valid(valid[3]), .meas_int(mi[3]), .meas_frac(mf[3]),
    .overflow(ovf[3]), .timeout(tmo[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, expv, cyc);
    end
  endtask

  // Gap list: first entry is start-to-sync, then n gaps of the given period.
  function automatic iq_t const_gaps(input int g0, input int n, input int per);
    iq_t q;
    q.push_back(g0);
    for (int i = 0; i < n; i++) q.push_back(per);
    return q;
  endfunction

  // Predict outcome of a gap schedule, then drive start and the pulse train.
  task automatic run_meas(input int d, input int lg, input int tmax, input iq_t gaps,
                          input int busy_j, input int idle);
    int   n;
    int   pos[$];
    int   acc;
    int   end_j;
    int   k;
    logic to_e;
    longint res;
    exp_t e;
    n   = 1 << lg;
    acc = 0;
    foreach (gaps[i]) begin
      acc += gaps[i];
      pos.push_back(acc);
    end
    to_e  = 1'b0;
    end_j = 0;
    if (gaps[0] > tmax) begin
      to_e  = 1'b1;
      end_j = tmax + 1;
    end else begin
      for (int i = 1; i <= n; i++) begin
        if (!to_e && gaps[i] > tmax) begin
          to_e  = 1'b1;
          end_j = pos[i-1] + tmax + 1;
        end
      end
      if (!to_e) end_j = pos[n] + 1;
    end
    if (to_e) begin
      e.mi = last_mi[d];
      e.mf = last_mf[d];
      e.v  = 1'b0;
      e.o  = 1'b0;
      e.t  = 1'b1;
    end else begin
      res = (longint'(pos[n] - pos[0]) * 256) >> lg;
      e.o = (res > 64'hFF_FFFF);
      if (e.o) res = 64'hFF_FFFF;
      e.mi = 16'(res >> 8);
      e.mf = 8'(res);
      e.v  = 1'b1;
      e.t  = 1'b0;
      last_mi[d] = e.mi;
      last_mf[d] = e.mf;
    end
    repeat (idle) begin
      @(posedge clk); #1;
      pen[d] = 1'b0;
      st[d]  = 1'b0;
    end
    @(posedge clk); #1;
    pen[d] = 1'b0;
    st[d]  = 1'b1;
    e.due  = cyc + end_j;
    exp_q[d].push_back(e);
    k = 0;
    for (int j = 1; j < end_j; j++) begin
      @(posedge clk); #1;
      st[d] = (j == busy_j);
      if (k < pos.size() && pos[k] == j) begin
        pen[d] = 1'b1;
        k++;
      end else begin
        pen[d] = 1'b0;
      end
      if (j == 1) chk("busy_after_start", d, 32'(busy[d]), 32'd1);
    end
  endtask

  task automatic idle_out(input int d);
    @(posedge clk); #1;
    pen[d] = 1'b0;
    st[d]  = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (done[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected none (cycle %0d)", d, cyc);
        end else begin
          mon_e = exp_q[d].pop_front();
          chk("done_cycle",   d, 32'(cyc),      32'(mon_e.due));
          chk("meas_int",     d, 32'(mi[d]),    32'(mon_e.mi));
          chk("meas_frac",    d, 32'(mf[d]),    32'(mon_e.mf));
          chk("valid",        d, 32'(valid[d]), 32'(mon_e.v));
          chk("overflow",     d, 32'(ovf[d]),   32'(mon_e.o));
          chk("timeout",      d, 32'(tmo[d]),   32'(mon_e.t));
          chk("busy_at_done", d, 32'(busy[d]),  32'd0);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    for (int d = 0; d < 4; d++) begin
      rst[d]     = 1'b1;
      pen[d]     = 1'b0;
      st[d]      = 1'b0;
      last_mi[d] = '0;
      last_mf[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_busy",  d, 32'(busy[d]),  32'd0);
      chk("rst_done",  d, 32'(done[d]),  32'd0);
      chk("rst_valid", d, 32'(valid[d]), 32'd0);
      chk("rst_int",   d, 32'(mi[d]),    32'd0);
      chk("rst_frac",  d, 32'(mf[d]),    32'd0);
      chk("rst_ovf",   d, 32'(ovf[d]),   32'd0);
      chk("rst_tmo",   d, 32'(tmo[d]),   32'd0);
      rst[d] = 1'b0;
    end

    fork
      begin : main_seq
        iq_t g;
        run_meas(0, 8, 131072, const_gaps(1, 256, 1), 0, 0);
        run_meas(0, 8, 131072, const_gaps(2, 256, 3), 0, 2);
        g = {};
        g.push_back(1);
        for (int i = 0; i < 256; i++) g.push_back((i % 2) ? 3 : 2);
        run_meas(0, 8, 131072, g, 0, 0);
        // Reset in the middle of a measurement: no done, state cleared.
        @(posedge clk); #1;
        pen[0] = 1'b0;
        st[0]  = 1'b1;
        repeat (40) begin
          @(posedge clk); #1;
          st[0]  = 1'b0;
          pen[0] = 1'b1;
        end
        @(posedge clk); #1;
        pen[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("post_reset_busy",  0, 32'(busy[0]),  32'd0);
        chk("post_reset_valid", 0, 32'(valid[0]), 32'd0);
        chk("post_reset_int",   0, 32'(mi[0]),    32'd0);
        last_mi[0] = '0;
        last_mf[0] = '0;
        repeat (3) @(posedge clk);
        for (int r = 0; r < 5; r++) begin
          g = {};
          for (int i = 0; i <= 256; i++) g.push_back(int'($urandom_range(1, 6)));
          run_meas(0, 8, 131072, g, int'($urandom_range(2, 300)), int'($urandom_range(0, 2)));
        end
        idle_out(0);
      end

      begin : to_seq
        iq_t g;
        run_meas(1, 8, 16, const_gaps(3, 256, 1), 0, 0);
        run_meas(1, 8, 16, const_gaps(100, 256, 1), 0, 1);
        run_meas(1, 8, 16, const_gaps(16, 256, 16), 0, 0);
        g = const_gaps(2, 256, 1);
        g[11] = 17;
        run_meas(1, 8, 16, g, 0, 2);
        run_meas(1, 8, 16, const_gaps(1, 256, 2), 0, 0);
        idle_out(1);
      end

      begin : ovf_seq
        run_meas(2, 0, 131072, const_gaps(5, 1, 70000), 0, 0);
        run_meas(2, 0, 131072, const_gaps(1, 1, 1000), 0, 1);
        run_meas(2, 0, 131072, const_gaps(3, 1, 1), 0, 0);
        idle_out(2);
      end

      begin : rnd_seq
        iq_t g;
        for (int r = 0; r < 40; r++) begin
          g = {};
          for (int i = 0; i <= 8; i++) begin
            if ($urandom_range(0, 15) == 0) g.push_back(int'($urandom_range(30, 34)));
            else g.push_back(int'($urandom_range(1, 12)));
          end
          run_meas(3, 3, 32, g, int'($urandom_range(2, 40)), int'($urandom_range(0, 2)));
        end
        idle_out(3);
      end
    join

    repeat (5) @(posedge clk);
    for (int d = 0; d < 4; d++) chk("pending_results", d, 32'(exp_q[d].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_divider_meter.md
Name: pio_divider_meter

Overview:
- Measures the rate of a PIO clock-enable pulse train and reports it as a 16.8 fixed-point divisor, in the same format the divider consumes (int 16 bits, frac 8 bits).
- Sits beside the PIO state-machine clock dividers as a self-check and debug block. Software starts a measurement, then reads back the divisor that produced the observed penable stream.
- Counts clock cycles across 2^LOG2_PULSES enable pulses.

Parameters:
- LOG2_PULSES, 8, log2 of the number of penable pulses averaged per measurement; legal range 0..8.
- TIMEOUT, 131072, maximum cycles allowed between successive counted pulses (and from start to the sync pulse) before aborting.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- penable  input  1  enable pulse train under measurement; sampled high = one pulse that cycle
- start  input  1  single-cycle request to begin a measurement
- busy  output  1  high while a measurement is in progress
- done  output  1  one-cycle pulse when a measurement ends (success or abort)
- valid  output  1  sticky; result fields hold a good measurement
- meas_int  output  16  measured divisor, integer part
- meas_frac  output  8  measured divisor, fractional part
- overflow  output  1  sticky; last result saturated
- timeout  output  1  sticky; last measurement aborted by watchdog

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the rising clk edge.
- Reset values:
  - FSM = IDLE.
  - busy = done = valid = overflow = timeout = 0.
  - meas_int = meas_frac = 0.
  - All counters = 0.
- FSM states: IDLE, SYNC, MEASURE.
- IDLE, start=1:
  - Next state SYNC, busy=1.
  - Clear valid, overflow, timeout, cycle counter, pulse counter and watchdog.
- SYNC:
  - Watchdog increments every cycle.
  - penable=1: next state MEASURE; clear cyc_cnt, pulse_cnt and watchdog. This pulse is not counted; it marks time zero.
  - Watchdog reaches TIMEOUT-1 without penable: abort.
- MEASURE, every cycle:
  - cyc_cnt increments, saturating at all-ones. Width is 17+LOG2_PULSES bits.
  - penable=1: pulse_cnt increments and watchdog clears. Otherwise watchdog increments.
- MEASURE, completion: penable=1 while pulse_cnt == 2^LOG2_PULSES-1.
  - C = cyc_cnt+1, i.e. the count including the current cycle.
  - result = (C << 8) >> LOG2_PULSES, computed at full width.
  - result > 24'hFFFFFF: {meas_int,meas_frac} = 24'hFFFFFF and overflow=1. Otherwise {meas_int,meas_frac} = result[23:0].
  - valid=1, done=1 for one cycle, busy=0, next state IDLE.
  - Outputs update on the edge after the final pulse cycle; latency is 1 cycle.
- Abort (watchdog reaches TIMEOUT-1 in SYNC or MEASURE):
  - timeout=1, valid=0, done=1 for one cycle, busy=0, next state IDLE.
  - meas_int and meas_frac keep their previous values.
  - Completion wins over timeout if both occur in the same cycle.
- start while busy is ignored; the measurement continues unaffected.
- start in the same cycle as done (FSM already IDLE on the next edge) is accepted only if FSM == IDLE when start is sampled.
- reset during SYNC or MEASURE returns the block to its reset state immediately. There is no done pulse.
- penable held permanently high (divider bypassed, or div_int = 1) measures exactly 1.0: meas_int=1, meas_frac=0.
- Arithmetic:
  - All unsigned.
  - Fractional results truncate; there is no rounding.
  - LOG2_PULSES=8 makes the result equal to C directly.

Test Plan:
- penable constant 1, LOG2_PULSES=8, pulse start -> done 257 cycles later (1 sync + 256 pulses); meas_int=0x0001, meas_frac=0x00, valid=1, overflow=0, timeout=0.
- penable one pulse every 3 cycles -> C=768; meas_int=0x0003, meas_frac=0x00.
- penable periods alternating 2,3,2,3... (divisor 2.5) -> C=640; meas_int=0x0002, meas_frac=0x80.
- penable held 0 after start, TIMEOUT=16 (override) -> done pulse 16 cycles after start; timeout=1, valid=0, previous meas fields unchanged.
- Overflow: LOG2_PULSES=0 (override) and pulse gap 70000 cycles, TIMEOUT=131072 -> C=70000, result=17,920,000 > 24'hFFFFFF (16,777,215); result fields = 0xFFFF/0xFF, overflow=1, valid=1.
- Reset mid-MEASURE, then start pulses while busy -> after reset busy=0, done never pulses for the aborted run. A start during a subsequent busy run is ignored and its result matches an undisturbed run.
